// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//
// Receives PS/2 device-to-host frames (start, 8 data bits LSB first, odd parity, stop) from the
// raw ps2_clk/ps2_data pins. It synchronises and deglitches both lines, shifts the frame in on
// each filtered falling edge of ps2_clk, and checks the start, parity and stop bits. Each good
// byte is presented with a one-cycle strobe. Each rejected frame produces a one-cycle
// frame_error pulse instead.
//
// Parameters:
//   SYNC_STAGES    - synchroniser depth per PS/2 line (>= 2)
//   FILTER_LEN     - consecutive differing samples before the filtered clock flips (>= 1)
//   TIMEOUT_CYCLES - idle clk cycles allowed between bit events inside a frame (< 2**15)
//
// Ports:
//   clk                    in   system clock, rising edge
//   rst                    in   asynchronous active-high reset
//   ps2_clk                in   raw PS/2 clock (asynchronous)
//   ps2_data               in   raw PS/2 data (asynchronous)
//   ps2_received_data      out  last good byte, held until the next good frame
//   ps2_received_data_strb out  one-cycle pulse when ps2_received_data updates
//   frame_error            out  one-cycle pulse on a rejected frame
//   busy                   out  high whenever a frame is in progress
//
// Build option:
//   PS2_WATCHDOG_EN - when defined, a frame that stalls for TIMEOUT_CYCLES between bit events is
//                     abandoned with a frame_error pulse. When undefined, a stalled frame waits
//                     indefinitely and later edges continue it.

module ps2_frame_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_received_data,
  output logic       ps2_received_data_strb,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  // Wide enough to hold FILTER_LEN-1; the flip happens instead of reaching FILTER_LEN.
  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

  // ---------------------------------------------------------------------------------------------
  // Synchronisers (idle-high bus, so reset to 1)
  // ---------------------------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_sync;
  logic                   data_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_sync  = clk_sync_q[SYNC_STAGES-1];
  assign data_sync = data_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------------------------
  // Clock deglitch filter
  // ---------------------------------------------------------------------------------------------
  logic             filt_q;
  logic             filt_d;
  logic             filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic [FiltW-1:0] filt_cnt_d;
  logic             bit_event;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync != filt_q) begin
      if (filt_cnt_q == FiltLast) begin
        filt_d = ~filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Registered falling edge of the filtered clock; data is sampled in this same cycle.
  assign bit_event = filt_prev_q & ~filt_q;

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  state_e      state_q;
  state_e      state_d;
  logic [2:0]  bitcnt_q;
  logic [2:0]  bitcnt_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        parity_q;
  logic        parity_d;
  logic [7:0]  data_q;
  logic [7:0]  data_d;
  logic        strb_q;
  logic        strb_d;
  logic        err_q;
  logic        err_d;
  logic        wd_timeout;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    data_d   = data_q;
    strb_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A high start bit is line noise, not a frame; ignore it.
        if (bit_event && !data_sync) begin
          state_d  = StData;
          bitcnt_d = 3'd0;
        end
      end
      StData: begin
        if (bit_event) begin
          shift_d  = {data_sync, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (bit_event) begin
          parity_d = data_sync;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (bit_event) begin
          // Odd parity: data bits plus parity bit must contain an odd number of ones.
          if (data_sync && ((^shift_q) ^ parity_q)) begin
            data_d = shift_q;
            strb_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abandon a stalled frame. Never coincides with a stop event, since the watchdog
    // cannot expire in a cycle that carries a bit event.
    if (wd_timeout) begin
      state_d = StIdle;
      strb_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
      data_q   <= 8'h00;
      strb_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Inter-bit watchdog
  // ---------------------------------------------------------------------------------------------
`ifdef PS2_WATCHDOG_EN
  localparam logic [14:0] WdLast = 15'(TIMEOUT_CYCLES - 1);

  logic [14:0] wd_q;
  logic [14:0] wd_d;

  always_comb begin
    wd_d = wd_q + 15'd1;
    if (state_q == StIdle || bit_event) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_timeout = (state_q != StIdle) && !bit_event && (wd_q == WdLast);
`else
  // Without the watchdog a truncated frame simply waits for more edges.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_timeout         = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign ps2_received_data      = data_q;
  assign ps2_received_data_strb = strb_q;
  assign frame_error            = err_q;
  assign busy                   = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

  localparam int unsigned Sync = 2;
  localparam int unsigned Filt = 4;
  localparam int unsigned To   = 20000;
  // Raw fall of ps2_clk to registered strobe/error (and to busy rising on the start bit).
  localparam int          Lat  = Sync + Filt + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_strb;
  logic       frame_error;
  logic       busy;

  always #50 clk = ~clk;  // 10 MHz

  ps2_frame_receiver #(
    .SYNC_STAGES   (Sync),
    .FILTER_LEN    (Filt),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ps2_clk               (ps2_clk),
    .ps2_data              (ps2_data),
    .ps2_received_data     (rx_data),
    .ps2_received_data_strb(rx_strb),
    .frame_error           (frame_error),
    .busy                  (busy)
  );

  int total = 0;
  int bad   = 0;

  // Pulse monitor, sampled away from the active edge.
  int         strb_cnt    = 0;
  int         err_cnt     = 0;
  int         overlap_cnt = 0;
  int         wide_cnt    = 0;
  logic       strb_prev   = 1'b0;
  logic [7:0] strb_data   = 8'h00;

  always @(negedge clk) begin
    if (rx_strb) begin
      strb_cnt  <= strb_cnt + 1;
      strb_data <= rx_data;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
    if (rx_strb && frame_error) overlap_cnt <= overlap_cnt + 1;
    if (rx_strb && strb_prev) wide_cnt <= wide_cnt + 1;
    strb_prev <= rx_strb;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives frame[0..nbits-1] LSB first: data set at start of the high phase, then a fall.
  // busy_lat: cycles from the first fall until busy is seen high.
  // done_lat: cycles from the last fall until strobe or frame_error is seen high.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input int half,
                           input bit glitch, output int busy_lat, output int done_lat);
    busy_lat = -1;
    done_lat = -1;
    if (glitch) begin
      // Idle glitch with data low: a false event here would start a bogus frame.
      ps2_data = 1'b0;
      tick(10);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(10);
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      if (glitch && i == 3) begin
        tick(8);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(half - 11);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b0;
      for (int k = 1; k <= half; k++) begin
        tick(1);
        if (i == 0 && busy && busy_lat < 0) busy_lat = k;
        if (i == nbits - 1 && (rx_strb || frame_error) && done_lat < 0) done_lat = k;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] val;
    logic       par;
    logic       stop;
    bit         glitch;
    int         half;
    bit         exp_strb;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int         s0;
    int         e0;
    int         bl;
    int         dl;
    int         wd_lat;
    logic [10:0] f;

    //           val    par   stop  glt  half exp_strb exp_err exp_data
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 400, 1'b1, 1'b0, 8'h1C};  // 12.5 kHz
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b0, 20,  1'b1, 1'b0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 1'b0, 20,  1'b0, 1'b1, 8'hF0};  // parity error
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 20,  1'b0, 1'b1, 8'hF0};  // stop error
    vecs[4] = '{8'h29, 1'b0, 1'b1, 1'b1, 20,  1'b1, 1'b0, 8'h29};  // glitches
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 20,  1'b1, 1'b0, 8'h00};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 20,  1'b0, 1'b1, 8'h00};  // parity error
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b0, 20,  1'b1, 1'b0, 8'hFF};
    vecs[8] = '{8'h81, 1'b1, 1'b1, 1'b1, 20,  1'b1, 1'b0, 8'h81};

    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(3);
    check("reset data", 32'(rx_data), 32'h00);
    check("reset strobe", 32'(rx_strb), 32'h0);
    check("reset frame_error", 32'(frame_error), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(10);

    for (int i = 0; i < 9; i++) begin
      s0 = strb_cnt;
      e0 = err_cnt;
      f  = {vecs[i].stop, vecs[i].par, vecs[i].val, 1'b0};
      send_bits(f, 11, vecs[i].half, vecs[i].glitch, bl, dl);
      tick(20);
      check($sformatf("v%0d strobes", i), 32'(strb_cnt - s0), 32'(vecs[i].exp_strb));
      check($sformatf("v%0d errors", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d busy after", i), 32'(busy), 32'h0);
      check($sformatf("v%0d busy latency", i), 32'(bl), 32'(Lat));
      check($sformatf("v%0d pulse latency", i), 32'(dl), 32'(Lat));
      if (vecs[i].exp_strb) begin
        check($sformatf("v%0d data at strobe", i), 32'(strb_data), 32'(vecs[i].exp_data));
      end
    end

    // Reset after start + 4 data bits: asynchronous clear, then a clean frame.
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    send_bits(f, 5, 20, 1'b0, bl, dl);
    tick(5);
    check("pre-reset busy", 32'(busy), 32'h1);
    #20;
    rst = 1'b1;
    #5;
    check("async reset data", 32'(rx_data), 32'h00);
    check("async reset strobe", 32'(rx_strb), 32'h0);
    check("async reset frame_error", 32'(frame_error), 32'h0);
    check("async reset busy", 32'(busy), 32'h0);
    tick(3);
    rst = 1'b0;
    tick(10);
    s0 = strb_cnt;
    e0 = err_cnt;
    send_bits(f, 11, 20, 1'b0, bl, dl);
    tick(20);
    check("post-reset strobes", 32'(strb_cnt - s0), 32'h1);
    check("post-reset errors", 32'(err_cnt - e0), 32'h0);
    check("post-reset data", 32'(rx_data), 32'h1C);

    // Truncated frame: start + 4 data bits, then a long stall.
    f  = {1'b1, 1'b1, 8'hF0, 1'b0};
    s0 = strb_cnt;
    e0 = err_cnt;
    send_bits(f, 5, 20, 1'b0, bl, dl);
`ifdef PS2_WATCHDOG_EN
    wd_lat = -1;
    for (int k = 1; k <= 25000; k++) begin
      tick(1);
      if (frame_error && wd_lat < 0) wd_lat = k + 20;  // +20: low phase already elapsed
    end
    check("timeout error pulses", 32'(err_cnt - e0), 32'h1);
    check("timeout no strobe", 32'(strb_cnt - s0), 32'h0);
    check("timeout busy", 32'(busy), 32'h0);
    check("timeout position", 32'(wd_lat >= int'(To + Sync + Filt) &&
                                  wd_lat <= int'(To + Sync + Filt + 2)), 32'h1);
    check("timeout data kept", 32'(rx_data), 32'h1C);
    s0 = strb_cnt;
    send_bits(f, 11, 20, 1'b0, bl, dl);
    tick(20);
    check("after timeout strobes", 32'(strb_cnt - s0), 32'h1);
    check("after timeout data", 32'(rx_data), 32'hF0);
`else
    tick(2000);
    check("stall busy held", 32'(busy), 32'h1);
    check("stall no error", 32'(err_cnt - e0), 32'h0);
    send_bits(f >> 5, 6, 20, 1'b0, bl, dl);
    tick(20);
    check("continued strobes", 32'(strb_cnt - s0), 32'h1);
    check("continued errors", 32'(err_cnt - e0), 32'h0);
    check("continued data", 32'(rx_data), 32'hF0);
    check("continued busy", 32'(busy), 32'h0);
`endif

    check("strobe/error overlap", 32'(overlap_cnt), 32'h0);
    check("strobe wider than 1", 32'(wide_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

- Receives raw PS/2 device-to-host frames on the `ps2_clk`/`ps2_data` pins.
- Synchronises and deglitches both lines, shifts in the 11-bit frame and checks start, odd parity and stop.
- Presents each good byte on `ps2_received_data` with a one-cycle `ps2_received_data_strb`, which is exactly the input pair consumed by `data_control`.
- Sits directly upstream of `data_control` in the PS/2-to-Morse path.

## Interface
- `SYNC_STAGES`, 2: flip-flop synchroniser depth on each PS/2 line (min 2).
- `FILTER_LEN`, 4: consecutive identical synchronised samples required before the filtered clock changes (min 1).
- `TIMEOUT_CYCLES`, 20000: idle-`clk` limit between filtered falling edges inside a frame (2 ms at 10 MHz).

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `ps2_received_data` out 8: last good byte.
- `ps2_received_data_strb` out 1: one-cycle pulse when `ps2_received_data` updates.
- `frame_error` out 1: one-cycle pulse on a rejected frame.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- Synchronisers: `SYNC_STAGES` flops per line, reset to 1.
- Filter:
  - Counts consecutive synchronised `ps2_clk` samples that differ from the current filtered value.
  - When the count reaches `FILTER_LEN`, the filtered value flips and the counter clears.
  - Any equal sample clears the counter.
  - The filtered value resets to 1.
- A filtered 1->0 transition is a "bit event". Data is taken from the synchronised `ps2_data` in that same cycle.
- FSM states:
  - IDLE, on bit event: data=0 -> DATA with bitcnt=0; data=1 -> stay IDLE, silently ignored.
  - DATA, on bit event: shift right with the new bit into bit 7, so the byte is LSB-first; bitcnt++. After the 8th bit -> PARITY.
  - PARITY, on bit event: store the parity bit -> STOP.
  - STOP, on bit event: if stop=1 and (XOR of 8 data bits ^ parity)=1, load the output register and pulse the strobe; otherwise pulse `frame_error`. Either way -> IDLE.
- `ps2_received_data` holds its value until the next good frame. A rejected frame never alters it.
- Bitcnt is 3 bits plus the state. There is no wrap beyond 8 because the transition out of DATA occurs at bitcnt=7 with an event.
- The strobe and `frame_error` are mutually exclusive and never both high.
- `rst` mid-frame: the FSM immediately returns to IDLE. The partial byte is discarded and nothing is strobed.
- Reset values: `ps2_received_data`=0x00, `ps2_received_data_strb`=0, `frame_error`=0, `busy`=0.

## Timing
- Raw `ps2_clk` fall to bit event: `SYNC_STAGES`+`FILTER_LEN` cycles, assuming a stable level.
- Strobe/error latency: registered, high in the cycle after the 11th bit event. That is `SYNC_STAGES`+`FILTER_LEN`+1 cycles after the raw 11th fall.
- `ps2_received_data` is valid in the same cycle as the strobe.
- The strobe is exactly 1 cycle wide, with no back-pressure. The consumer must sample on the strobe.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no event.
- `busy` rises the cycle after the start-bit event and falls together with the strobe/error pulse.

## Configuration
- `PS2_WATCHDOG_EN` defined:
  - A 15-bit counter (sized for `TIMEOUT_CYCLES`) clears on every bit event and in IDLE, and counts otherwise.
  - On reaching `TIMEOUT_CYCLES` while not IDLE: FSM -> IDLE, `frame_error` pulses for 1 cycle, partial byte discarded.
- `PS2_WATCHDOG_EN` undefined: no counter. A truncated frame leaves the FSM waiting in its current state, and later edges continue that frame.

## Test plan
- Good frame 0x1C: bits start 0, 0,0,1,1,1,0,0,0, parity 0, stop 1, at 12.5 kHz with `clk` 10 MHz -> `ps2_received_data`=0x1C, strobe high exactly 1 cycle, `frame_error` never high.
- Parity error: 0x1C sent with parity 1 after a prior good 0xF0 -> `frame_error` pulse, no strobe, data stays 0xF0.
- Stop error: 0x5A sent with stop=0 -> `frame_error` pulse, no strobe.
- Glitch: 3-cycle low pulses on `ps2_clk` with `FILTER_LEN`=4 during IDLE and mid-frame -> no bit events, subsequent good frame 0x29 received correctly.
- Timeout (macro on): 5 bits then 25000 idle cycles -> `frame_error` pulse at cycle 20000 after the last event, `busy`=0, then good frame 0xF0 (parity 1) -> data 0xF0, strobe.
- Reset mid-frame: assert `rst` after the 4th data bit -> outputs at reset values asynchronously, next full 0x1C frame received cleanly.
